// File: rtl/tx_hs_seq.sv
// tx_hs_seq: multi-lane D-PHY high-speed burst sequencer.
// One shared FSM walks every lane through LP-11 stop, HS-request, HS-prepare,
// HS-zero, sync byte, payload, HS-trail and HS-exit, using programmable
// per-state timers and a TxRequestHS/TxReadyHS handshake toward the
// lane-distribution layer. All Moore outputs are registered with the state.
module tx_hs_seq #(
  parameter int         LANES     = 2,
  parameter logic [7:0] SYNC_BYTE = 8'hB8,
  parameter int         CNT_W     = 8,
  parameter int         T_LPX     = 2,
  parameter int         T_PREP    = 3,
  parameter int         T_ZERO    = 4,
  parameter int         T_TRAIL   = 3,
  parameter int         T_EXIT    = 2
) (
  input  logic                 TxDDRClk,
  input  logic                 TxRst,
  input  logic                 TxRequestHS,
  input  logic [8*LANES-1:0]   TxDataHS,
  output logic                 TxReadyHS,
  output logic                 TxValid,
  output logic [8*LANES-1:0]   TxDataOut,
  output logic [1:0]           TxLP,
  output logic                 TxStopState
);

  localparam logic [2:0] STOP     = 3'd0;
  localparam logic [2:0] HS_RQST  = 3'd1;
  localparam logic [2:0] HS_PREP  = 3'd2;
  localparam logic [2:0] HS_ZERO  = 3'd3;
  localparam logic [2:0] HS_SYNC  = 3'd4;
  localparam logic [2:0] HS_DATA  = 3'd5;
  localparam logic [2:0] HS_TRAIL = 3'd6;
  localparam logic [2:0] HS_EXIT  = 3'd7;

  // Timer reload values: a state lasting T cycles loads T-1 and exits at 0.
  localparam logic [CNT_W-1:0] LD_LPX   = CNT_W'(T_LPX - 1);
  localparam logic [CNT_W-1:0] LD_PREP  = CNT_W'(T_PREP - 1);
  localparam logic [CNT_W-1:0] LD_ZERO  = CNT_W'(T_ZERO - 1);
  localparam logic [CNT_W-1:0] LD_TRAIL = CNT_W'(T_TRAIL - 1);
  localparam logic [CNT_W-1:0] LD_EXIT  = CNT_W'(T_EXIT - 1);

  localparam logic [8*LANES-1:0] SYNC_WORD = {LANES{SYNC_BYTE}};

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [CNT_W-1:0]   timer;
  logic [CNT_W-1:0]   timer_nxt;
  logic               expired;
  logic [8*LANES-1:0] dout_nxt;
  logic [1:0]         lp_nxt;
  logic               valid_nxt;
  logic               stop_nxt;

  // Trail level per lane: the inverse of the last serialized bit (bit 7,
  // since bytes go out LSB-first) of that lane's final byte.
  function automatic logic [8*LANES-1:0] trail_word(input logic [8*LANES-1:0] last);
    logic [8*LANES-1:0] w;
    w = '0;
    for (int i = 0; i < LANES; i++) begin
      w[8*i +: 8] = {8{~last[8*i+7]}};
    end
    return w;
  endfunction

  assign expired   = (timer == '0);
  assign TxReadyHS = (state == HS_SYNC) || (state == HS_DATA);

  // Next-state, timer and next output-byte decode.
  always_comb begin
    state_nxt = state;
    timer_nxt = expired ? timer : timer - CNT_W'(1);
    dout_nxt  = TxDataOut;
    case (state)
      STOP: begin
        dout_nxt = '0;
        if (TxRequestHS) begin
          state_nxt = HS_RQST;
          timer_nxt = LD_LPX;
        end
      end
      HS_RQST: begin
        if (expired) begin
          state_nxt = HS_PREP;
          timer_nxt = LD_PREP;
        end
      end
      HS_PREP: begin
        if (expired) begin
          state_nxt = HS_ZERO;
          timer_nxt = LD_ZERO;
        end
      end
      HS_ZERO: begin
        if (expired) begin
          state_nxt = HS_SYNC;
          timer_nxt = '0;
          dout_nxt  = SYNC_WORD;
        end
      end
      HS_SYNC, HS_DATA: begin
        // TxDataOut holds the sync word or the last captured payload here,
        // so the trail is derived straight from the output register.
        if (TxRequestHS) begin
          state_nxt = HS_DATA;
          dout_nxt  = TxDataHS;
        end else begin
          state_nxt = HS_TRAIL;
          timer_nxt = LD_TRAIL;
          dout_nxt  = trail_word(TxDataOut);
        end
      end
      HS_TRAIL: begin
        if (expired) begin
          state_nxt = HS_EXIT;
          timer_nxt = LD_EXIT;
          dout_nxt  = '0;
        end
      end
      HS_EXIT: begin
        if (expired) begin
          state_nxt = STOP;
          timer_nxt = '0;
        end
      end
      default: begin
        state_nxt = STOP;
        timer_nxt = '0;
        dout_nxt  = '0;
      end
    endcase
  end

  // Moore output decode from the next state, so outputs register with it.
  always_comb begin
    lp_nxt    = 2'b00;
    valid_nxt = 1'b0;
    stop_nxt  = 1'b0;
    case (state_nxt)
      STOP:     begin lp_nxt = 2'b11; stop_nxt = 1'b1; end
      HS_RQST:  lp_nxt = 2'b01;
      HS_PREP:  lp_nxt = 2'b00;
      HS_EXIT:  lp_nxt = 2'b11;
      default:  begin lp_nxt = 2'b00; valid_nxt = 1'b1; end
    endcase
  end

  // State and timer registers with asynchronous active-low reset.
  always_ff @(posedge TxDDRClk or negedge TxRst) begin
    if (!TxRst) begin
      state <= STOP;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Registered line outputs; reset forces LP-11 stop with drivers off.
  always_ff @(posedge TxDDRClk or negedge TxRst) begin
    if (!TxRst) begin
      TxDataOut   <= '0;
      TxLP        <= 2'b11;
      TxValid     <= 1'b0;
      TxStopState <= 1'b1;
    end else begin
      TxDataOut   <= dout_nxt;
      TxLP        <= lp_nxt;
      TxValid     <= valid_nxt;
      TxStopState <= stop_nxt;
    end
  end

endmodule

// File: tb/tb_tx_hs_seq.sv
// tb_tx_hs_seq: directed bench for tx_hs_seq, default 2-lane instance plus a
// 1-lane instance with shortened request and zero timers.
module tb_tx_hs_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a;
  logic [15:0] data_a;
  logic        ready_a;
  logic        valid_a;
  logic [15:0] dout_a;
  logic [1:0]  lp_a;
  logic        stop_a;
  logic        req_b;
  logic [7:0]  data_b;
  logic        ready_b;
  logic        valid_b;
  logic [7:0]  dout_b;
  logic [1:0]  lp_b;
  logic        stop_b;

  int checks = 0;
  int errors = 0;
  int ready_cnt;

  always #5 clk = ~clk;

  tx_hs_seq dut_a (
    .TxDDRClk    (clk),
    .TxRst       (rst),
    .TxRequestHS (req_a),
    .TxDataHS    (data_a),
    .TxReadyHS   (ready_a),
    .TxValid     (valid_a),
    .TxDataOut   (dout_a),
    .TxLP        (lp_a),
    .TxStopState (stop_a)
  );

  tx_hs_seq #(.LANES(1), .T_LPX(1), .T_ZERO(1)) dut_b (
    .TxDDRClk    (clk),
    .TxRst       (rst),
    .TxRequestHS (req_b),
    .TxDataHS    (data_b),
    .TxReadyHS   (ready_b),
    .TxValid     (valid_b),
    .TxDataOut   (dout_b),
    .TxLP        (lp_b),
    .TxStopState (stop_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input string tag, input logic [1:0] lp, input logic v,
                       input logic r, input logic s, input logic [15:0] d);
    check({tag, ".lp"},    {30'd0, lp_a},    {30'd0, lp});
    check({tag, ".valid"}, {31'd0, valid_a}, {31'd0, v});
    check({tag, ".ready"}, {31'd0, ready_a}, {31'd0, r});
    check({tag, ".stop"},  {31'd0, stop_a},  {31'd0, s});
    check({tag, ".data"},  {16'd0, dout_a},  {16'd0, d});
  endtask

  task automatic exp_b(input string tag, input logic [1:0] lp, input logic v,
                       input logic r, input logic s, input logic [7:0] d);
    check({tag, ".lp"},    {30'd0, lp_b},    {30'd0, lp});
    check({tag, ".valid"}, {31'd0, valid_b}, {31'd0, v});
    check({tag, ".ready"}, {31'd0, ready_b}, {31'd0, r});
    check({tag, ".stop"},  {31'd0, stop_b},  {31'd0, s});
    check({tag, ".data"},  {24'd0, dout_b},  {24'd0, d});
  endtask

  // Edges 'first'..8 after the request: 2 x LP-01, 3 x LP-00 prepare,
  // 4 x HS-zero; then the sync edge. Request dropped after edge drop_at.
  task automatic preamble_a(input string tag, input int first, input int drop_at);
    for (int i = first; i < 9; i++) begin
      tick;
      if (i < 2)      exp_a({tag, ".rqst"}, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000);
      else if (i < 5) exp_a({tag, ".prep"}, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
      else            exp_a({tag, ".zero"}, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000);
      ready_cnt += int'(ready_a);
      if (i == drop_at) req_a = 1'b0;
    end
    tick;
    exp_a({tag, ".sync"}, 2'b00, 1'b1, 1'b1, 1'b0, 16'hB8B8);
    ready_cnt += int'(ready_a);
  endtask

  task automatic trail_exit_a(input string tag, input logic [15:0] trail);
    for (int i = 0; i < 3; i++) begin
      tick;
      exp_a({tag, ".trail"}, 2'b00, 1'b1, 1'b0, 1'b0, trail);
      ready_cnt += int'(ready_a);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      exp_a({tag, ".exit"}, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000);
      ready_cnt += int'(ready_a);
    end
  endtask

  initial begin
    rst    = 1'b1;
    req_a  = 1'b0;
    data_a = '0;
    req_b  = 1'b0;
    data_b = '0;
    ready_cnt = 0;

    // Power-on reset
    #1 rst = 1'b0;
    #2;
    exp_a("rst_init_a", 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000);
    exp_b("rst_init_b", 2'b11, 1'b0, 1'b0, 1'b1, 8'h00);
    tick;
    tick;
    @(negedge clk) rst = 1'b1;
    tick;
    exp_a("idle", 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000);

    // Single burst of three words
    req_a = 1'b1;
    preamble_a("b1", 0, -1);
    data_a = 16'h1234;
    tick;
    exp_a("b1.w0", 2'b00, 1'b1, 1'b1, 1'b0, 16'h1234);
    data_a = 16'h5678;
    tick;
    exp_a("b1.w1", 2'b00, 1'b1, 1'b1, 1'b0, 16'h5678);
    data_a = 16'hA5C3;
    tick;
    exp_a("b1.w2", 2'b00, 1'b1, 1'b1, 1'b0, 16'hA5C3);
    req_a = 1'b0;
    trail_exit_a("b1", 16'h0000);
    tick;
    exp_a("b1.stop", 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000);

    // Trail polarity per lane
    req_a = 1'b1;
    preamble_a("pol", 0, -1);
    data_a = 16'h7F80;
    tick;
    exp_a("pol.w0", 2'b00, 1'b1, 1'b1, 1'b0, 16'h7F80);
    req_a = 1'b0;
    trail_exit_a("pol", 16'hFF00);
    tick;
    exp_a("pol.stop", 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000);

    // Zero-payload burst: request dropped during HS-zero
    ready_cnt = 0;
    req_a = 1'b1;
    preamble_a("zp", 0, 5);
    trail_exit_a("zp", 16'h0000);
    tick;
    exp_a("zp.stop", 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("zp.ready_cycles", ready_cnt, 32'd1);

    // Back-to-back: request re-raised during trail, held through exit
    req_a = 1'b1;
    preamble_a("bb", 0, -1);
    data_a = 16'h807F;
    tick;
    exp_a("bb.w0", 2'b00, 1'b1, 1'b1, 1'b0, 16'h807F);
    req_a = 1'b0;
    tick;
    exp_a("bb.trail0", 2'b00, 1'b1, 1'b0, 1'b0, 16'h00FF);
    req_a = 1'b1;
    tick;
    exp_a("bb.trail1", 2'b00, 1'b1, 1'b0, 1'b0, 16'h00FF);
    tick;
    exp_a("bb.trail2", 2'b00, 1'b1, 1'b0, 1'b0, 16'h00FF);
    tick;
    exp_a("bb.exit0", 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick;
    exp_a("bb.exit1", 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick;
    exp_a("bb.stop", 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick;
    exp_a("bb.rqst", 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Asynchronous reset in the middle of the payload
    preamble_a("mr", 1, -1);
    data_a = 16'hBEEF;
    tick;
    exp_a("mr.w0", 2'b00, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    #2;
    rst   = 1'b0;
    req_a = 1'b0;
    #1;
    exp_a("mr.rst", 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000);
    @(negedge clk) rst = 1'b1;
    tick;
    exp_a("mr.after0", 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick;
    exp_a("mr.after1", 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000);

    // Short-timer single-lane instance
    req_b = 1'b1;
    tick;
    exp_b("sb.rqst", 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick;
      exp_b("sb.prep", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    tick;
    exp_b("sb.zero", 2'b00, 1'b1, 1'b0, 1'b0, 8'h00);
    tick;
    exp_b("sb.sync", 2'b00, 1'b1, 1'b1, 1'b0, 8'hB8);
    data_b = 8'h3C;
    tick;
    exp_b("sb.w0", 2'b00, 1'b1, 1'b1, 1'b0, 8'h3C);
    req_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      exp_b("sb.trail", 2'b00, 1'b1, 1'b0, 1'b0, 8'hFF);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      exp_b("sb.exit", 2'b11, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    tick;
    exp_b("sb.stop", 2'b11, 1'b0, 1'b0, 1'b1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
